textlcd_resp: RTL



---
 rtl/textlcd_resp.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/textlcd_resp.sv
// textlcd_resp -- display-side responder for the 8-bit HD44780-style text-LCD bus.
//
// Samples lcd_e/lcd_rs/lcd_rw/lcd_data_in on clk and executes each transfer on
// the falling edge of lcd_e. Keeps a 2x16 DDRAM image, the address counter and
// the busy flag, and answers busy-flag and data reads.
//
// Ports:
//   clk, resetn            system clock, synchronous active-low reset
//   lcd_e/rs/rw/data_in    bus from the writer (enable, reg select, read/write, data)
//   lcd_data_out/oe        read data and its registered drive enable
//   rd_addr / rd_char      debug DDRAM port (0-15 line 1, 16-31 line 2), 1-cycle latency
//   ac, busy               address counter and busy flag
//   disp_on, entry_id,func display-on, entry increment, {DL,N,F}
//   cmd_strobe             1-cycle pulse per accepted transfer
//   err_busy               sticky: a write arrived while busy
//
// Optional build macro: TEXTLCD_RESP_SHIFT_EN adds the display-shift offset.
module textlcd_resp #(
  parameter int BUSY_CMD = 4,
  parameter int CLR_LEN  = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       entry_id,
  output logic [2:0] func,
  output logic       cmd_strobe,
  output logic       err_busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CLEAR = 2'd1, ST_EXEC = 2'd2} state_t;

  localparam logic [7:0] BLANK     = 8'h20;
  localparam logic [4:0] CLR_LAST  = 5'(CLR_LEN - 1);
  localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CMD);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [4:0] clr_idx_r;
  logic [7:0] ddram_r [0:31];
  logic       e_d_r, rs_r, rw_r;
  logic [7:0] data_r;
  logic [6:0] ac_r;
  logic       busy_r, disp_on_r, entry_id_r, err_busy_r, cmd_strobe_r, oe_r;
  logic [2:0] func_r;
  logic [7:0] dout_r, rd_char_r;
  logic       fall_s, wr_fall_s, rd_fall_s;
  logic [5:0] ac_slot_s;
  logic [7:0] ac_char_s, dbg_char_s;
`ifdef TEXTLCD_RESP_SHIFT_EN
  logic [5:0] offset_r;
  logic       entry_s_r;
  logic [5:0] pos_s;
`endif

  // AC step with the two-line wrap points (0x27<->0x40, 0x67<->0x00).
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // {hit, entry}: 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31, anything else misses.
  function automatic logic [5:0] ac_map(input logic [6:0] a);
    logic [5:0] r;
    if (a[5:4] == 2'b00) r = {1'b1, a[6], a[3:0]};
    else                 r = 6'd0;
    return r;
  endfunction

`ifdef TEXTLCD_RESP_SHIFT_EN
  // Display offset step, modulo the 40-character line length.
  function automatic logic [5:0] off_step(input logic [5:0] o, input logic inc);
    logic [5:0] r;
    if (inc) r = (o == 6'd39) ? 6'd0 : o + 6'd1;
    else     r = (o == 6'd0) ? 6'd39 : o - 6'd1;
    return r;
  endfunction
`endif

  // Fall detection and combinational lookups into the DDRAM image.
  always_comb begin
    fall_s    = e_d_r & ~lcd_e;
    wr_fall_s = fall_s & ~rw_r;
    rd_fall_s = fall_s & rw_r;
    ac_slot_s = ac_map(ac_r);
    if (ac_slot_s[5]) ac_char_s = ddram_r[ac_slot_s[4:0]];
    else              ac_char_s = BLANK;
`ifdef TEXTLCD_RESP_SHIFT_EN
    pos_s = {2'b00, rd_addr[3:0]} + offset_r;
    if (pos_s >= 6'd40) pos_s = pos_s - 6'd40;
    else                pos_s = pos_s;
    if (pos_s < 6'd16) dbg_char_s = ddram_r[{rd_addr[4], pos_s[3:0]}];
    else               dbg_char_s = BLANK;
`else
    dbg_char_s = ddram_r[rd_addr];
`endif
  end

  // Bus capture, transfer execution and the IDLE/CLEAR/EXEC sequencer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      clr_idx_r    <= 5'd0;
      for (int i = 0; i < 32; i++) ddram_r[i] <= BLANK;
      e_d_r        <= 1'b0;
      rs_r         <= 1'b0;
      rw_r         <= 1'b0;
      data_r       <= 8'd0;
      ac_r         <= 7'd0;
      busy_r       <= 1'b0;
      disp_on_r    <= 1'b0;
      entry_id_r   <= 1'b1;
      func_r       <= 3'd0;
      err_busy_r   <= 1'b0;
      cmd_strobe_r <= 1'b0;
      oe_r         <= 1'b0;
      dout_r       <= 8'd0;
      rd_char_r    <= BLANK;
`ifdef TEXTLCD_RESP_SHIFT_EN
      offset_r     <= 6'd0;
      entry_s_r    <= 1'b0;
`endif
    end else begin
      e_d_r <= lcd_e;
      if (lcd_e) begin
        rs_r   <= lcd_rs;
        rw_r   <= lcd_rw;
        data_r <= lcd_data_in;
      end
      oe_r <= lcd_e & lcd_rw;
      // Read data tracks live state for as long as the writer holds the read.
      if (lcd_e & lcd_rw) dout_r <= lcd_rs ? ac_char_s : {busy_r, ac_r};
      rd_char_r    <= dbg_char_s;
      cmd_strobe_r <= 1'b0;

      if (wr_fall_s && busy_r) begin
        err_busy_r <= 1'b1;
      end else if (wr_fall_s) begin
        cmd_strobe_r <= 1'b1;
        state_r      <= ST_EXEC;
        cnt_r        <= BUSY_LOAD;
        busy_r       <= 1'b1;
        if (rs_r) begin
          if (ac_slot_s[5]) ddram_r[ac_slot_s[4:0]] <= data_r;
          ac_r <= ac_step(ac_r, entry_id_r);
`ifdef TEXTLCD_RESP_SHIFT_EN
          if (entry_s_r) offset_r <= off_step(offset_r, entry_id_r);
`endif
        end else begin
          // Highest set bit selects the instruction.
          casez (data_r)
            8'b1???????: ac_r <= (data_r[5:0] > 6'h27) ? 7'h00 : data_r[6:0];
            8'b01??????: ac_r <= ac_r;  // CGRAM address: accepted, not modelled
            8'b001?????: func_r <= data_r[4:2];
            8'b0001????: begin
              if (!data_r[3]) ac_r <= ac_step(ac_r, data_r[2]);
`ifdef TEXTLCD_RESP_SHIFT_EN
              else offset_r <= off_step(offset_r, data_r[2]);
`else
              else ac_r <= ac_r;
`endif
            end
            8'b00001???: disp_on_r <= data_r[2];
            8'b000001??: begin
              entry_id_r <= data_r[1];
`ifdef TEXTLCD_RESP_SHIFT_EN
              entry_s_r  <= data_r[0];
`endif
            end
            8'b0000001?: begin
              ac_r <= 7'h00;
`ifdef TEXTLCD_RESP_SHIFT_EN
              offset_r <= 6'd0;
`endif
            end
            8'b00000001: begin
              state_r   <= ST_CLEAR;
              clr_idx_r <= 5'd0;
            end
            default: ac_r <= ac_r;
          endcase
        end
      end else if (rd_fall_s) begin
        if (rs_r) begin
          cmd_strobe_r <= 1'b1;
          ac_r         <= ac_step(ac_r, entry_id_r);
        end
      end

      // Sequencer; sits after transfer handling so the end of a clear wins over a read.
      case (state_r)
        ST_IDLE: begin
        end
        ST_CLEAR: begin
          ddram_r[clr_idx_r] <= BLANK;
          clr_idx_r          <= clr_idx_r + 5'd1;
          if (clr_idx_r == CLR_LAST) begin
            state_r    <= ST_EXEC;
            cnt_r      <= BUSY_LOAD;
            ac_r       <= 7'h00;
            entry_id_r <= 1'b1;
`ifdef TEXTLCD_RESP_SHIFT_EN
            offset_r   <= 6'd0;
`endif
          end
        end
        ST_EXEC: begin
          cnt_r <= cnt_r - 8'd1;
          if (cnt_r <= 8'd1) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 8'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign lcd_data_out = dout_r;
  assign lcd_data_oe  = oe_r;
  assign rd_char      = rd_char_r;
  assign ac           = ac_r;
  assign busy         = busy_r;
  assign disp_on      = disp_on_r;
  assign entry_id     = entry_id_r;
  assign func         = func_r;
  assign cmd_strobe   = cmd_strobe_r;
  assign err_busy     = err_busy_r;

endmodule
